// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: state codes, opcodes,
// and the select encodings that the datapath muxes and immediate extender decode.
package ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH   = 4'd0;
   localparam state_t S_DECODE  = 4'd1;
   localparam state_t S_MEMADR  = 4'd2;
   localparam state_t S_MEMRD   = 4'd3;
   localparam state_t S_MEMWB   = 4'd4;
   localparam state_t S_MEMWR   = 4'd5;
   localparam state_t S_EXEC_R  = 4'd6;
   localparam state_t S_EXEC_I  = 4'd7;
   localparam state_t S_ALUWB   = 4'd8;
   localparam state_t S_BRANCH  = 4'd9;
   localparam state_t S_JAL     = 4'd10;
   localparam state_t S_JALR    = 4'd11;
   localparam state_t S_JALR_WB = 4'd12;
   localparam state_t S_UPPER   = 4'd13;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // Also consumed by the immediate extender; keep the numbering stable.
   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_J = 3'd3,
      IMM_U = 3'd4
   } imm_src_t;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_t;

   // What kind of ALU work the current state needs; the decoder refines it from funct bits.
   typedef enum logic [2:0] {
      AC_ADD    = 3'd0,
      AC_OP_R   = 3'd1,
      AC_OP_I   = 3'd2,
      AC_BRANCH = 3'd3,
      AC_PASS_B = 3'd4
   } alu_class_t;

   typedef enum logic [1:0] {
      SRC_A_PC     = 2'd0,
      SRC_A_OLD_PC = 2'd1,
      SRC_A_RS1    = 2'd2
   } src_a_t;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'd0,
      SRC_B_IMM  = 2'd1,
      SRC_B_FOUR = 2'd2
   } src_b_t;

   typedef enum logic [1:0] {
      RES_ALU_REG = 2'd0,
      RES_MEM     = 2'd1,
      RES_ALU_OUT = 2'd2
   } result_src_t;

   typedef struct packed {
      logic        pc_write;
      logic        ir_write;
      logic        adr_src;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      imm_src_t    imm_src;
      src_a_t      alu_src_a;
      src_b_t      alu_src_b;
      result_src_t result_src;
      alu_class_t  alu_class;
      logic        illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: turns the state's ALU class plus funct3/funct7[5]
// into the concrete ALU operation.
module alu_decoder
   import ctrl_pkg::*;
(
   input  alu_class_t alu_class_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_b5_i,
   output alu_op_t    alu_op_o
);

   always_comb begin
      alu_op_o = ALU_ADD;
      case (alu_class_i)
         AC_PASS_B: alu_op_o = ALU_PASS_B;
         AC_BRANCH: begin
            case (funct3_i[2:1])
               2'b10:   alu_op_o = ALU_SLT;
               2'b11:   alu_op_o = ALU_SLTU;
               default: alu_op_o = ALU_SUB;
            endcase
         end
         AC_OP_R, AC_OP_I: begin
            // funct7[5] only selects SUB on register ops and SRA/SRAI on right shifts.
            case (funct3_i)
               3'b000:  alu_op_o = (alu_class_i == AC_OP_R && funct7_b5_i) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op_o = ALU_SLL;
               3'b010:  alu_op_o = ALU_SLT;
               3'b011:  alu_op_o = ALU_SLTU;
               3'b100:  alu_op_o = ALU_XOR;
               3'b101:  alu_op_o = funct7_b5_i ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op_o = ALU_OR;
               default: alu_op_o = ALU_AND;
            endcase
         end
         default: alu_op_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over the shared datapath, with memory states stalling on mem_ready.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ALU_OPW = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        instr,
   input  logic               zero,
   input  logic               lt,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               adr_src,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic [2:0]         imm_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALU_OPW-1:0] alu_ctrl,
   output logic [1:0]         result_src,
   output logic               illegal
);

   if (XLEN != 32) begin : g_bad_xlen
      $error("multicycle_ctrl is written for XLEN = 32 only");
   end

   state_t     state_q, state_d;
   ctrl_t      ctrl;
   alu_op_t    alu_op;
   logic       branch_taken;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      case (funct3)
         3'b000:         branch_taken = zero;
         3'b001:         branch_taken = ~zero;
         3'b100, 3'b110: branch_taken = lt;
         3'b101, 3'b111: branch_taken = ~lt;
         default:        branch_taken = 1'b0;
      endcase
   end

   always_comb begin
      // NOTE: defaults first, so no path through the case below can infer a latch.
      ctrl    = '0;
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_a = SRC_A_PC;
            ctrl.alu_src_b = SRC_B_FOUR;
            if (mem_ready) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
               state_d       = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is precomputed here; JAL borrows this cycle for its own target.
            ctrl.alu_src_a = SRC_A_OLD_PC;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.imm_src   = (opcode == OPC_JAL) ? IMM_J : IMM_B;
            case (opcode)
               OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
               OPC_OP:              state_d = S_EXEC_R;
               OPC_OP_IMM:          state_d = S_EXEC_I;
               OPC_BRANCH:          state_d = S_BRANCH;
               OPC_JAL:             state_d = S_JAL;
               OPC_JALR:            state_d = S_JALR;
               OPC_LUI, OPC_AUIPC:  state_d = S_UPPER;
               default: begin
                  ctrl.illegal = 1'b1;
                  state_d      = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            if (opcode == OPC_STORE) begin
               ctrl.imm_src = IMM_S;
               state_d      = S_MEMWR;
            end else begin
               ctrl.imm_src = IMM_I;
               state_d      = S_MEMRD;
            end
         end
         S_MEMRD: begin
            ctrl.adr_src  = 1'b1;
            ctrl.mem_read = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ctrl.result_src = RES_MEM;
            ctrl.reg_write  = 1'b1;
            state_d         = S_FETCH;
         end
         S_MEMWR: begin
            ctrl.adr_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_class = AC_OP_R;
            state_d        = S_ALUWB;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.imm_src   = IMM_I;
            ctrl.alu_class = AC_OP_I;
            state_d        = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl.result_src = RES_ALU_REG;
            ctrl.reg_write  = 1'b1;
            state_d         = S_FETCH;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_class = AC_BRANCH;
            ctrl.pc_write  = branch_taken;
            state_d        = S_FETCH;
         end
         S_JAL: begin
            // Link value comes straight off the ALU; the target already sits in the ALU reg.
            ctrl.alu_src_a  = SRC_A_OLD_PC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.result_src = RES_ALU_OUT;
            ctrl.reg_write  = 1'b1;
            ctrl.pc_write   = 1'b1;
            state_d         = S_FETCH;
         end
         S_JALR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.imm_src   = IMM_I;
            ctrl.pc_write  = 1'b1;
            state_d        = S_JALR_WB;
         end
         S_JALR_WB: begin
            ctrl.alu_src_a  = SRC_A_OLD_PC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.result_src = RES_ALU_OUT;
            ctrl.reg_write  = 1'b1;
            state_d         = S_FETCH;
         end
         S_UPPER: begin
            ctrl.imm_src   = IMM_U;
            ctrl.alu_src_b = SRC_B_IMM;
            if (opcode == OPC_LUI) begin
               ctrl.alu_src_a = SRC_A_PC;
               ctrl.alu_class = AC_PASS_B;
            end else begin
               ctrl.alu_src_a = SRC_A_OLD_PC;
            end
            state_d = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_class_i (ctrl.alu_class),
      .funct3_i    (funct3),
      .funct7_b5_i (instr[30]),
      .alu_op_o    (alu_op)
   );

   // Outputs are forced low while rst_n is low, so a reset mid-access drops the request at once.
   assign pc_write   = rst_n & ctrl.pc_write;
   assign ir_write   = rst_n & ctrl.ir_write;
   assign adr_src    = rst_n & ctrl.adr_src;
   assign mem_read   = rst_n & ctrl.mem_read;
   assign mem_write  = rst_n & ctrl.mem_write;
   assign reg_write  = rst_n & ctrl.reg_write;
   assign illegal    = rst_n & ctrl.illegal;
   assign imm_src    = {3{rst_n}} & ctrl.imm_src;
   assign alu_src_a  = {2{rst_n}} & ctrl.alu_src_a;
   assign alu_src_b  = {2{rst_n}} & ctrl.alu_src_b;
   assign result_src = {2{rst_n}} & ctrl.result_src;
   assign alu_ctrl   = {ALU_OPW{rst_n}} & ALU_OPW'(alu_op);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction scenarios plus a randomized
// run, each cycle compared against a step-list reference model of the control sequence.
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        zero, lt, mem_ready;
   logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal;
   logic [2:0]  imm_src;
   logic [1:0]  alu_src_a, alu_src_b, result_src;
   logic [3:0]  alu_ctrl;

   multicycle_ctrl #(.XLEN(32), .ALU_OPW(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .lt(lt), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .imm_src(imm_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .result_src(result_src), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef enum int {
      K_FETCH, K_DECODE, K_MEMADR, K_MEMRD, K_MEMWB, K_MEMWR, K_EXEC_R,
      K_EXEC_I, K_ALUWB, K_BRANCH, K_JAL, K_JALR, K_JALR_WB, K_UPPER
   } kind_t;

   typedef struct packed {
      logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
      logic [2:0] imm_src;
      logic [1:0] alu_src_a, alu_src_b;
      logic [3:0] alu_ctrl;
      logic [1:0] result_src;
      logic       illegal;
   } outs_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   kind_t       cur      = K_FETCH;
   kind_t       rest[$];
   logic [31:0] next_ins = '0;
   outs_t       last_o;
   kind_t       last_kind;
   outs_t       seen [14];
   int          cnt_regw, cnt_rd, cnt_wr, cnt_ill, cnt_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] opc);
      logic [6:0] legal [9];
      legal = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      foreach (legal[i]) if (legal[i] == opc) return 1'b1;
      return 1'b0;
   endfunction

   // Sequence of steps an instruction walks through after its fetch.
   task automatic build_plan(input logic [31:0] ins);
      rest.delete();
      rest.push_back(K_DECODE);
      case (ins[6:0])
         7'h03: begin rest.push_back(K_MEMADR); rest.push_back(K_MEMRD); rest.push_back(K_MEMWB); end
         7'h23: begin rest.push_back(K_MEMADR); rest.push_back(K_MEMWR); end
         7'h33: begin rest.push_back(K_EXEC_R); rest.push_back(K_ALUWB); end
         7'h13: begin rest.push_back(K_EXEC_I); rest.push_back(K_ALUWB); end
         7'h63: rest.push_back(K_BRANCH);
         7'h6F: rest.push_back(K_JAL);
         7'h67: begin rest.push_back(K_JALR); rest.push_back(K_JALR_WB); end
         7'h37, 7'h17: begin rest.push_back(K_UPPER); rest.push_back(K_ALUWB); end
         default: ;
      endcase
   endtask

   function automatic outs_t model_out(input kind_t k, input logic [31:0] ins,
                                       input logic z, input logic l, input logic mr);
      outs_t      o;
      alu_op_t    by_f3 [8];
      logic [2:0] f3;
      logic       take;
      o     = '0;
      f3    = ins[14:12];
      by_f3 = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      take  = (f3[2:1] == 2'b01) ? 1'b0 : ((f3[2] ? l : z) ^ f3[0]);
      case (k)
         K_FETCH:   begin o.mem_read = 1; o.alu_src_b = 2; o.ir_write = mr; o.pc_write = mr; end
         K_DECODE:  begin
            o.alu_src_a = 1; o.alu_src_b = 1;
            o.imm_src   = (ins[6:0] == 7'h6F) ? 3'd3 : 3'd2;
            o.illegal   = !is_legal(ins[6:0]);
         end
         K_MEMADR:  begin o.alu_src_a = 2; o.alu_src_b = 1; o.imm_src = (ins[6:0] == 7'h23) ? 3'd1 : 3'd0; end
         K_MEMRD:   begin o.adr_src = 1; o.mem_read = 1; end
         K_MEMWB:   begin o.result_src = 1; o.reg_write = 1; end
         K_MEMWR:   begin o.adr_src = 1; o.mem_write = 1; end
         K_EXEC_R, K_EXEC_I: begin
            o.alu_src_a = 2;
            o.alu_src_b = (k == K_EXEC_I) ? 2'd1 : 2'd0;
            o.alu_ctrl  = by_f3[f3];
            if (ins[30] && f3 == 3'd5) o.alu_ctrl = ALU_SRA;
            if (ins[30] && f3 == 3'd0 && k == K_EXEC_R) o.alu_ctrl = ALU_SUB;
         end
         K_ALUWB:   o.reg_write = 1;
         K_BRANCH:  begin
            o.alu_src_a = 2;
            o.alu_ctrl  = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            o.pc_write  = take;
         end
         K_JAL, K_JALR_WB: begin
            o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2; o.reg_write = 1;
            o.pc_write  = (k == K_JAL);
         end
         K_JALR:    begin o.alu_src_a = 2; o.alu_src_b = 1; o.pc_write = 1; end
         K_UPPER:   begin
            o.imm_src   = 3'd4; o.alu_src_b = 1;
            o.alu_src_a = (ins[6:0] == 7'h37) ? 2'd0 : 2'd1;
            o.alu_ctrl  = (ins[6:0] == 7'h37) ? ALU_PASS_B : ALU_ADD;
         end
         default: ;
      endcase
      return o;
   endfunction

   function automatic outs_t sample();
      outs_t o;
      o.pc_write = pc_write;   o.ir_write = ir_write;     o.adr_src = adr_src;
      o.mem_read = mem_read;   o.mem_write = mem_write;   o.reg_write = reg_write;
      o.imm_src = imm_src;     o.alu_src_a = alu_src_a;   o.alu_src_b = alu_src_b;
      o.alu_ctrl = alu_ctrl;   o.result_src = result_src; o.illegal = illegal;
      return o;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  opcs [10];
      int          pick;
      opcs = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
      r    = $urandom;
      pick = $urandom_range(0, 11);
      if (pick < 10) r[6:0] = opcs[pick];
      return r;
   endfunction

   // One clock: drive at negedge, compare at negedge+1, then advance the model.
   task automatic cycle(input bit rst, input bit mr, input bit z, input bit l);
      outs_t act, exp;
      @(negedge clk);
      rst_n = !rst; mem_ready = mr; zero = z; lt = l;
      #1;
      act = sample();
      exp = rst ? outs_t'('0) : model_out(cur, instr, z, l, mr);
      check($sformatf("outputs in %s", rst ? "RESET" : cur.name()), 32'(act), 32'(exp));
      last_o    = act;
      last_kind = cur;
      seen[int'(cur)] = act;
      cnt_cyc++;
      cnt_regw += int'(act.reg_write);
      cnt_rd   += int'(act.mem_read & act.adr_src);
      cnt_wr   += int'(act.mem_write);
      cnt_ill  += int'(act.illegal);
      if (rst) begin
         cur = K_FETCH;
         rest.delete();
      end else if (!((cur == K_FETCH || cur == K_MEMRD || cur == K_MEMWR) && !mr)) begin
         if (cur == K_FETCH) begin
            instr = next_ins;
            build_plan(instr);
         end
         cur = (rest.size() == 0) ? K_FETCH : rest.pop_front();
      end
   endtask

   task automatic exec(input logic [31:0] ins, input int stall, input bit z, input bit l);
      int left  = stall;
      int guard = 0;
      bit mr;
      cnt_regw = 0; cnt_rd = 0; cnt_wr = 0; cnt_ill = 0; cnt_cyc = 0;
      for (int i = 0; i < 14; i++) seen[i] = '0;
      next_ins = ins;
      do begin
         mr = 1'b1;
         if ((cur == K_MEMRD || cur == K_MEMWR) && left > 0) begin
            mr = 1'b0;
            left--;
         end
         cycle(1'b0, mr, z, l);
         guard++;
      end while (cur != K_FETCH && guard < 40);
      check($sformatf("instr %08h returns to FETCH within bound", ins), 32'(guard < 40), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; instr = '0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;

      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("reset: mem_read", 32'(last_o.mem_read), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("fetch after reset: mem_read", 32'(last_o.mem_read), 32'd1);
      check("fetch after reset: alu_src_b", 32'(last_o.alu_src_b), 32'd2);

      // LW with three stalled MEMRD cycles
      exec(32'h00012083, 3, 1'b0, 1'b0);
      check("lw cycles", 32'(cnt_cyc), 32'd8);
      check("lw memrd cycles", 32'(cnt_rd), 32'd4);
      check("lw reg_write cycles", 32'(cnt_regw), 32'd1);
      check("lw memwb result_src", 32'(seen[K_MEMWB].result_src), 32'd1);

      exec(32'h00112423, 2, 1'b0, 1'b0);
      check("sw memadr imm_src", 32'(seen[K_MEMADR].imm_src), 32'd1);
      check("sw mem_write cycles", 32'(cnt_wr), 32'd3);
      check("sw reg_write cycles", 32'(cnt_regw), 32'd0);

      exec(32'h00000063, 0, 1'b1, 1'b0);
      check("beq zero=1 pc_write", 32'(seen[K_BRANCH].pc_write), 32'd1);
      check("beq alu_ctrl", 32'(seen[K_BRANCH].alu_ctrl), 32'd1);
      exec(32'h00001063, 0, 1'b1, 1'b0);
      check("bne zero=1 pc_write", 32'(seen[K_BRANCH].pc_write), 32'd0);
      exec(32'h00006063, 0, 1'b0, 1'b1);
      check("bltu alu_ctrl", 32'(seen[K_BRANCH].alu_ctrl), 32'd4);
      check("bltu lt=1 pc_write", 32'(seen[K_BRANCH].pc_write), 32'd1);

      exec(32'h008000EF, 0, 1'b0, 1'b0);
      check("jal decode imm_src", 32'(seen[K_DECODE].imm_src), 32'd3);
      check("jal pc_write", 32'(seen[K_JAL].pc_write), 32'd1);
      check("jal reg_write cycles", 32'(cnt_regw), 32'd1);
      exec(32'h000080E7, 0, 1'b0, 1'b0);
      check("jalr imm_src", 32'(seen[K_JALR].imm_src), 32'd0);
      check("jalr pc_write", 32'(seen[K_JALR].pc_write), 32'd1);
      check("jalr reg_write cycles", 32'(cnt_regw), 32'd1);
      check("jalr cycles", 32'(cnt_cyc), 32'd4);

      exec(32'h0000007F, 0, 1'b0, 1'b0);
      check("illegal pulse cycles", 32'(cnt_ill), 32'd1);
      check("illegal cycles", 32'(cnt_cyc), 32'd2);
      check("illegal writes", 32'(cnt_regw + cnt_wr), 32'd0);

      exec(32'h123450B7, 0, 1'b0, 1'b0);
      check("lui imm_src", 32'(seen[K_UPPER].imm_src), 32'd4);
      check("lui alu_ctrl", 32'(seen[K_UPPER].alu_ctrl), 32'd10);
      check("lui alu_src_a", 32'(seen[K_UPPER].alu_src_a), 32'd0);
      check("lui aluwb reg_write", 32'(seen[K_ALUWB].reg_write), 32'd1);

      // Reset asserted while a load is waiting in MEMRD
      next_ins = 32'h00012083;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("memrd before reset: mem_read", 32'(last_o.mem_read & last_o.adr_src), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("reset mid-memrd: mem_read", 32'(last_o.mem_read), 32'd0);
      check("reset mid-memrd: all outputs", 32'(last_o), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("release: back in fetch", 32'(last_o.mem_read & !last_o.adr_src), 32'd1);

      for (int i = 0; i < 3000; i++) begin
         next_ins = rand_instr();
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 65,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
